pwm_duty_ramp: RTL and testbench
================================

// Module: pwm_duty_ramp
// PURPOSE
// - Upstream stage of the PWM generator: drives its duty-cycle input.
// - Accepts a target duty via valid/ready handshake and slews the applied duty toward it, STEP per PWM period.
// - Changes duty only on PWM period boundaries, so the generator never sees a mid-period update.
// - Provides soft-start/soft-stop for motor and LED loads.
// PARAMETERS
// - N       8  Duty width; must equal N of the downstream PWM generator. Period = 2**N-1 clk cycles.
// - STEP_W  4  Width of the step-size input.
// PORTS
// - clk          in   1       System clock, rising edge.
// - reset        in   1       Synchronous, active-low (0 = reset).
// - target_duty  in   N       Requested duty value.
// - target_valid in   1       target_duty is valid.
// - target_ready out  1       Block accepts a new target.
// - step         in   STEP_W  Duty increment per period; sampled every tick; 0 is treated as 1.
// - duty_cycle   out  N       Applied duty; connects to the generator's dutyCycle.
// - period_tick  out  1       1-cycle pulse on the last cycle of each PWM period.
// - ramp_busy    out  1       High while duty_cycle != latched target.
// - ramp_done    out  1       1-cycle pulse on the cycle duty_cycle first equals the target.
// BEHAVIOUR
// - Reset (reset==0 at a rising edge):
//   - period counter=0, duty_cycle=0, target register=0, state=IDLE.
//   - period_tick=0, ramp_busy=0, ramp_done=0, target_ready=0.
//   - target_ready rises on the first edge after reset is released.
// - Period counter:
//   - Counts 0..2**N-2, then wraps to 0. Runs freely in every state.
//   - period_tick=1 combinationally while count==2**N-2.
// - Handshake:
//   - Transfer occurs on a rising edge with target_valid && target_ready.
//   - target_ready=1 only in IDLE.
//   - Upstream must hold target_duty stable while valid && !ready.
// - FSM IDLE:
//   - On transfer, latch target.
//   - target==duty_cycle: stay IDLE and pulse ramp_done the next cycle (zero-length ramp).
//   - Otherwise go to RAMP; ramp_busy=1 from the next cycle.
// - FSM RAMP, updated only on edges where period_tick==1:
//   - s = (step==0) ? 1 : step, zero-extended to N+1 bits.
//   - Up (duty<target): duty = min(duty+s, target); computed at N+1 bits, no wrap past 2**N-1.
//   - Down (duty>target): duty = (duty<=target+s) ? target : duty-s; no underflow below 0.
//   - When the new duty==target: go to IDLE, ramp_busy=0 and ramp_done=1 on the following cycle, target_ready=1.
// - Latency and ordering:
//   - duty_cycle changes exactly one cycle after a period_tick, i.e. on cycle 0 of the new period.
//   - A transfer on a tick edge does not move duty on that edge; the first step is at the next tick.
// - duty_cycle only changes in RAMP. Outputs are registered except period_tick and target_ready.
// - Reset mid-ramp: duty_cycle returns to 0 immediately (hard stop); any pending target is discarded.
// CONFIGURATION
// - Macro PWM_DUTY_RAMP_RETARGET_EN.
// - Defined:
//   - target_ready=1 in RAMP as well.
//   - A transfer in RAMP replaces the target; direction is re-evaluated from the current duty_cycle.
//   - If the new target equals duty_cycle: go to IDLE and pulse ramp_done.
//   - A transfer coinciding with a tick uses the new target for that tick's step.
// - Undefined: target_ready=0 in RAMP; behaviour exactly as above.
// TESTING
// All scenarios use N=4 (period 15 cycles) and STEP_W=4.
// 1. Reset released, target 12 with step 4 sent at count 3:
//    - Duty is 0 -> 4 -> 8 -> 12 on the 3 successive ticks.
//    - ramp_done pulses once; target_ready is 0 throughout the ramp.
// 2. From duty 12, target 1 with step 5:
//    - Duty is 12 -> 7 -> 2 -> 1 (clamped, no underflow).
// 3. From 0, target 15 with step 15:
//    - Single step 0 -> 15, no wrap; target 15 with step 0 from 13 gives 13 -> 14 -> 15.
// 4. Target equal to current duty (duty 12, send 12):
//    - Stays IDLE, ramp_busy stays 0, ramp_done pulses the next cycle.
// 5. Reset asserted mid-ramp (duty 8, target 12):
//    - Next edge: duty 0, busy 0, ready 0; after release ready=1 and the counter restarts at 0.
// 6. RETARGET_EN defined: target 12 accepted, then target 2 accepted at duty 8 with step 4:
//    - Duty is 8 -> 4 -> 2.
//    - Undefined: the second valid waits until ready=1 after duty reaches 12.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp
//
// Upstream stage of the PWM generator. Accepts a target duty over a
// valid/ready handshake and slews the applied duty toward it by one step per
// PWM period. Duty updates happen only on period boundaries, so the
// downstream generator never sees a change in the middle of a period. This
// gives soft-start / soft-stop behaviour for motor and LED loads.
//
// Parameters
//   N       duty width; must match the downstream generator (period 2**N-1)
//   STEP_W  width of the step-size input
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset (0 = reset)
//   target_duty   requested duty value
//   target_valid  target_duty is valid
//   target_ready  block accepts a new target (combinational)
//   step          duty increment per period; 0 is treated as 1
//   duty_cycle    applied duty, registered
//   period_tick   1-cycle pulse on the last cycle of each period (combinational)
//   ramp_busy     high while duty_cycle differs from the latched target
//   ramp_done     1-cycle pulse when duty_cycle first equals the target
//
// Optional feature (macro PWM_DUTY_RAMP_RETARGET_EN):
//   When defined, a new target may also be accepted while ramping; the
//   direction is re-evaluated from the current duty, and a transfer on a
//   tick edge steps toward the new target on that same edge.
// ---------------------------------------------------------------------------
module pwm_duty_ramp #(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      target_duty,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic [STEP_W-1:0] step,
    output logic [N-1:0]      duty_cycle,
    output logic              period_tick,
    output logic              ramp_busy,
    output logic              ramp_done
);

    // Arithmetic width: one bit wider than both operands so that the
    // up-step sum and the down-step comparison never wrap.
    localparam int AW = (STEP_W > N) ? STEP_W + 1 : N + 1;

    // Last count of the period: 2**N-2.
    localparam logic [N-1:0] CNT_LAST = {{(N-1){1'b1}}, 1'b0};

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t         state_reg,  state_next;
    logic [N-1:0]   count_reg,  count_next;
    logic [N-1:0]   duty_reg,   duty_next;
    logic [N-1:0]   target_reg, target_next;
    logic           busy_reg,   busy_next;
    logic           done_reg,   done_next;
    // Holds target_ready low for the first cycle after reset release.
    logic           alive_reg;

    logic           xfer;
    logic [N-1:0]   eff_target;
    logic [AW-1:0]  s_ext;
    logic [AW-1:0]  duty_ext;
    logic [AW-1:0]  tgt_ext;
    logic [AW-1:0]  up_sum;
    logic [AW-1:0]  dn_diff;
    logic [N-1:0]   stepped;

    // ---------------- period counter (free running) ----------------
    assign period_tick = (count_reg == CNT_LAST);
    assign count_next  = period_tick ? '0 : count_reg + 1'b1;

    // ---------------- handshake ----------------
`ifdef PWM_DUTY_RAMP_RETARGET_EN
    assign target_ready = alive_reg;
`else
    assign target_ready = alive_reg && (state_reg == IDLE);
`endif
    assign xfer = target_valid && target_ready;

    // A target arriving on this edge takes effect for this edge's step.
    assign eff_target = xfer ? target_duty : target_reg;

    // ---------------- step arithmetic ----------------
    assign s_ext    = (step == '0) ? AW'(1) : AW'(step);
    assign duty_ext = AW'(duty_reg);
    assign tgt_ext  = AW'(eff_target);
    assign up_sum   = duty_ext + s_ext;
    assign dn_diff  = duty_ext - s_ext;

    always_comb begin
        stepped = duty_reg;
        if (duty_reg < eff_target) begin
            stepped = (up_sum >= tgt_ext) ? eff_target : up_sum[N-1:0];
        end else if (duty_reg > eff_target) begin
            // Compare against target+s rather than subtracting first, so the
            // result can never underflow below zero.
            stepped = (duty_ext <= tgt_ext + s_ext) ? eff_target : dn_diff[N-1:0];
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next  = state_reg;
        duty_next   = duty_reg;
        target_next = xfer ? target_duty : target_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    if (target_duty == duty_reg) begin
                        done_next = 1'b1;       // zero-length ramp
                    end else begin
                        state_next = RAMP;
                    end
                end
            end
            RAMP: begin
                if (xfer && (target_duty == duty_reg)) begin
                    // Only reachable with retargeting: new target already met.
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (period_tick) begin
                    duty_next = stepped;
                    if (stepped == eff_target) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == RAMP);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            duty_reg   <= '0;
            target_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            alive_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            duty_reg   <= duty_next;
            target_reg <= target_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            alive_reg  <= 1'b1;
        end
    end

    assign duty_cycle = duty_reg;
    assign ramp_busy  = busy_reg;
    assign ramp_done  = done_reg;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Testbench for pwm_duty_ramp with N=4 (period 15 cycles), STEP_W=4.
// Expected duty values are pushed to a queue when a target is sent and
// popped by a monitor whenever duty_cycle changes.
module tb_pwm_duty_ramp;
    localparam int N  = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  target_duty;
    logic          target_valid;
    logic          target_ready;
    logic [SW-1:0] step;
    logic [N-1:0]  duty_cycle;
    logic          period_tick;
    logic          ramp_busy;
    logic          ramp_done;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.N(N), .STEP_W(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .target_duty  (target_duty),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .step         (step),
        .duty_cycle   (duty_cycle),
        .period_tick  (period_tick),
        .ramp_busy    (ramp_busy),
        .ramp_done    (ramp_done)
    );

    int          checks = 0;
    int          errors = 0;
    int          exp_q[$];
    int          model_cnt  = 0;
    int          model_duty = 0;
    int          exp_done   = 0;
    int          done_cnt   = 0;
    logic [N-1:0] prev_duty = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference period counter.
    always @(posedge clk) begin
        if (!reset) model_cnt = 0;
        else        model_cnt = (model_cnt == 14) ? 0 : model_cnt + 1;
    end

    // Monitor: tick timing, ready during ramp, duty changes against scoreboard.
    always @(negedge clk) begin
        check("period_tick", period_tick, (model_cnt == 14));
        if (ramp_done === 1'b1) done_cnt++;
`ifndef PWM_DUTY_RAMP_RETARGET_EN
        if (ramp_busy === 1'b1) check("ready_in_ramp", target_ready, 0);
`endif
        if (duty_cycle !== prev_duty) begin
            check("duty_phase", model_cnt, 0);
            if (exp_q.size() == 0) check("duty_unexpected", duty_cycle, prev_duty);
            else                   check("duty_step", duty_cycle, exp_q.pop_front());
            $display("duty %0d -> %0d", prev_duty, duty_cycle);
            prev_duty = duty_cycle;
        end
    end

    // Reference ramp: pushes every intermediate duty toward t.
    task automatic model_ramp(input int t, input int s);
        int se;
        int d;
        se = (s == 0) ? 1 : s;
        d  = model_duty;
        while (d != t) begin
            if (d < t) d = (d + se > t) ? t : d + se;
            else       d = (d - se < t) ? t : d - se;
            exp_q.push_back(d);
        end
        model_duty = t;
        exp_done++;
    endtask

    // Drive a target from a negedge; returns on the negedge after transfer.
    task automatic send(input int t, input int s);
        int k;
        k = 0;
        target_duty  = N'(t);
        step         = SW'(s);
        target_valid = 1'b1;
        while (target_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", (k < 200), 1);
        @(negedge clk);
        target_valid = 1'b0;
        $display("sent target %0d step %0d", t, s);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((ramp_busy !== 1'b0 || exp_q.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, (k < 400), 1);
        @(negedge clk);
        check({tag, "_duty"}, duty_cycle, model_duty);
        check({tag, "_done_count"}, done_cnt, exp_done);
        check({tag, "_done_single"}, ramp_done, 0);
    endtask

    task automatic wait_duty(input int v);
        int k;
        k = 0;
        while (duty_cycle !== N'(v) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("wait_duty_timeout", (k < 400), 1);
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        target_valid = 1'b0;
        target_duty  = '0;
        step         = '0;
        repeat (3) @(negedge clk);
        check("rst_duty", duty_cycle, 0);
        check("rst_busy", ramp_busy, 0);
        check("rst_done", ramp_done, 0);
        check("rst_ready", target_ready, 0);
        check("rst_tick", period_tick, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", target_ready, 1);
        @(negedge clk);

        // 1: 0 -> 4 -> 8 -> 12
        send(12, 4);
        model_ramp(12, 4);
        check("s1_busy", ramp_busy, 1);
        wait_idle("s1");

        // 2: 12 -> 7 -> 2 -> 1
        send(1, 5);
        model_ramp(1, 5);
        check("s2_busy", ramp_busy, 1);
        wait_idle("s2");

        // 3: back to 0, full-scale single step, then step 0 treated as 1
        send(0, 15);  model_ramp(0, 15);  wait_idle("s3a");
        send(15, 15); model_ramp(15, 15); wait_idle("s3b");
        send(13, 2);  model_ramp(13, 2);  wait_idle("s3c");
        send(15, 0);  model_ramp(15, 0);  wait_idle("s3d");

        // 4: zero-length ramp
        send(12, 3);  model_ramp(12, 3);  wait_idle("s4a");
        send(12, 3);
        model_ramp(12, 3);
        check("s4_done_pulse", ramp_done, 1);
        check("s4_busy", ramp_busy, 0);
        @(negedge clk);
        check("s4_done_clear", ramp_done, 0);
        check("s4_done_count", done_cnt, exp_done);

        // 5: reset in the middle of a ramp
        send(0, 15);  model_ramp(0, 15);  wait_idle("s5a");
        send(12, 4);
        model_ramp(12, 4);
        wait_duty(8);
        exp_q.delete();
        exp_q.push_back(0);
        model_duty = 0;
        exp_done--;
        reset = 1'b0;
        @(negedge clk);
        check("s5_duty", duty_cycle, 0);
        check("s5_busy", ramp_busy, 0);
        check("s5_ready", target_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("s5_ready_release", target_ready, 1);
        check("s5_done", ramp_done, 0);

        // 6: second target while ramping
        send(12, 4);
        model_ramp(12, 4);
        wait_duty(8);
`ifdef PWM_DUTY_RAMP_RETARGET_EN
        check("s6_ready_ramp", target_ready, 1);
        exp_q.delete();
        model_duty = 8;
        exp_done--;
        send(2, 4);
        model_ramp(2, 4);
`else
        check("s6_ready_ramp", target_ready, 0);
        send(2, 4);
        check("s6_duty_at_accept", duty_cycle, 12);
        model_ramp(2, 4);
`endif
        wait_idle("s6");

        check("done_total", done_cnt, exp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
